// File: rtl/counter_mod_updown.sv
// counter_mod_updown
//   WIDTH-bit modulo counter (range 0..MAX_VAL) with up/down direction,
//   synchronous clear/load, a clock-enable prescaler and a one-shot mode
//   that halts at the terminal count.
//
// Ports
//   clock       rising-edge clock
//   reset_n     asynchronous active-low reset
//   enable      count enable; low freezes counter, prescaler and state
//   up_down     1 = count up, 0 = count down
//   one_shot    1 = halt at terminal, 0 = wrap
//   clear       synchronous clear (highest priority)
//   load        synchronous load of load_value (clamped to MAX_VAL)
//   load_value  value for load
//   out         registered count
//   tc          one-cycle terminal-count pulse, concurrent with wrapped/held out
//   done        high while halted in one-shot mode
module counter_mod_updown #(
    parameter int WIDTH    = 8,
    parameter int MAX_VAL  = 2**WIDTH - 1,
    parameter int PRESCALE = 1
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             enable,
    input  logic             up_down,
    input  logic             one_shot,
    input  logic             clear,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    output logic [WIDTH-1:0] out,
    output logic             tc,
    output logic             done
);

    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [WIDTH-1:0] TOP   = WIDTH'(MAX_VAL);
    localparam logic [PW-1:0]    PLAST = PW'(PRESCALE - 1);

    typedef enum logic {RUN, HALT} state_t;

    state_t           state, state_nxt;
    logic [PW-1:0]    presc, presc_nxt;
    logic [WIDTH-1:0] out_nxt;
    logic             tc_nxt, done_nxt;
    logic             step, at_term;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= RUN;
            presc <= '0;
            out   <= '0;
            tc    <= 1'b0;
            done  <= 1'b0;
        end else begin
            state <= state_nxt;
            presc <= presc_nxt;
            out   <= out_nxt;
            tc    <= tc_nxt;
            done  <= done_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        presc_nxt = presc;
        out_nxt   = out;
        tc_nxt    = 1'b0;
        done_nxt  = done;

        step    = enable && (presc == PLAST);
        // Terminal is detected before the increment/decrement, so the
        // arithmetic never leaves WIDTH bits.
        at_term = up_down ? (out == TOP) : (out == '0);

        if (clear) begin
            state_nxt = RUN;
            presc_nxt = '0;
            out_nxt   = '0;
            done_nxt  = 1'b0;
        end else if (load) begin
            state_nxt = RUN;
            presc_nxt = '0;
            out_nxt   = (load_value > TOP) ? TOP : load_value;
            done_nxt  = 1'b0;
        end else if (enable) begin
            // Prescaler free-runs while enabled, also in HALT.
            presc_nxt = step ? '0 : presc + PW'(1);
            if (step && state == RUN) begin
                if (at_term) begin
                    tc_nxt = 1'b1;
                    if (one_shot) begin
                        state_nxt = HALT;
                        done_nxt  = 1'b1;
                    end else begin
                        out_nxt = up_down ? '0 : TOP;
                    end
                end else begin
                    out_nxt = up_down ? out + WIDTH'(1) : out - WIDTH'(1);
                end
            end
        end
    end

endmodule
